// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-side arbiter and its helpers.
// Imported by the arbiter, its bus interface and any future read-side scheduler.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int DEF_N_REQ     = 4;
   localparam int DEF_DATA_W    = 128;
   localparam int DEF_DEPTH     = 8;
   localparam int DEF_MAX_BURST = 4;
   localparam int DEF_CNT_W     = 4;

   // One extra bit so occupancy plus the in-flight write cannot overflow.
   function automatic int space_w(input int cnt_w);
      return cnt_w + 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side request bus and FIFO write port of the write arbiter.
// slave is the arbiter's view; master is the producers/FIFO side.
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ  = DEF_N_REQ,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
);

   logic [N_REQ-1:0]        req;
   logic [N_REQ-1:0]        req_last;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        gnt;
   logic [CNT_W-1:0]        fifo_cnt;
   logic                    fifo_wr;
   logic [DATA_W-1:0]       fifo_data;
   logic                    busy;

   modport slave (
      input  req, req_last, req_data, fifo_cnt,
      output gnt, fifo_wr, fifo_data, busy
   );

   modport master (
      output req, req_last, req_data, fifo_cnt,
      input  gnt, fifo_wr, fifo_data, busy
   );

endinterface

// File: rtl/rr_priority_pick.sv
// Round-robin pick: rotate requests so the slot after last_ptr is bit 0,
// priority-encode the lowest set bit, then map the offset back to an index.
module rr_priority_pick #(
   parameter int N     = 4,
   parameter int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] last_ptr,
   output logic [PTR_W-1:0] winner,
   output logic             found
);

   logic [PTR_W-1:0] start;
   logic [PTR_W-1:0] offset;
   logic [2*N-1:0]   dbl;
   logic [N-1:0]     rotated;
   logic [PTR_W:0]   sum;

   always_comb begin
      // NOTE: every variable gets a value before any branch; a path that skips an assignment infers a latch.
      start   = (last_ptr == PTR_W'(N - 1)) ? '0 : last_ptr + 1'b1;
      dbl     = {req, req};
      rotated = dbl[start +: N];
      offset  = '0;
      found   = |req;
      for (int i = N - 1; i >= 0; i--) begin
         if (rotated[i]) offset = PTR_W'(i);
      end
      // Explicit modulo keeps non-power-of-2 requester counts correct.
      sum = {1'b0, start} + {1'b0, offset};
      if (sum >= (PTR_W + 1)'(N)) winner = PTR_W'(sum - (PTR_W + 1)'(N));
      else                        winner = PTR_W'(sum);
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing one FIFO write port among N_REQ
// producers; throttles on FIFO occupancy and drives the write port from registers.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ     = DEF_N_REQ,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int MAX_BURST = DEF_MAX_BURST,
   parameter int CNT_W     = DEF_CNT_W
) (
   input logic               clock,
   input logic               rst,
   fifo_wr_arbiter_if.slave  bus
);

   localparam int PTR_W       = $clog2(N_REQ);
   localparam int BEATS_W     = $clog2(MAX_BURST + 1);
   localparam int SPACE_W     = space_w(CNT_W);
   localparam bit SINGLE_BEAT = (MAX_BURST == 1);

   arb_state_e         state_q, state_d;
   logic [PTR_W-1:0]   last_ptr_q, last_ptr_d;
   logic [PTR_W-1:0]   owner_q, owner_d;
   logic [BEATS_W-1:0] beats_q, beats_d;
   logic               fifo_wr_q;
   logic [DATA_W-1:0]  fifo_data_q;

   logic [PTR_W-1:0]   winner;
   logic               found;
   logic [SPACE_W-1:0] occupancy;
   logic               space_ok;
   logic [N_REQ-1:0]   gnt_c;
   logic               take;
   logic [PTR_W-1:0]   take_idx;
   logic [DATA_W-1:0]  take_beat;

   rr_priority_pick #(
      .N     (N_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req      (bus.req),
      .last_ptr (last_ptr_q),
      .winner   (winner),
      .found    (found)
   );

   // The registered write still in flight counts as occupied; concurrent reads are ignored.
   assign occupancy = {1'b0, bus.fifo_cnt} + SPACE_W'(fifo_wr_q);
   assign space_ok  = occupancy < SPACE_W'(DEPTH);

   always_comb begin
      state_d    = state_q;
      last_ptr_d = last_ptr_q;
      owner_d    = owner_q;
      beats_d    = beats_q;
      gnt_c      = '0;
      take       = 1'b0;
      take_idx   = owner_q;

      unique case (state_q)
         IDLE: begin
            if (found && space_ok) begin
               gnt_c[winner] = 1'b1;
               take          = 1'b1;
               take_idx      = winner;
               owner_d       = winner;
               beats_d       = BEATS_W'(1);
               if (bus.req_last[winner] || SINGLE_BEAT) last_ptr_d = winner;
               else                                     state_d    = BURST;
            end
         end
         BURST: begin
            if (!bus.req[owner_q]) begin
               // Owner went quiet: release the lock and forfeit the rest of the burst.
               state_d    = IDLE;
               last_ptr_d = owner_q;
            end else if (space_ok) begin
               gnt_c[owner_q] = 1'b1;
               take           = 1'b1;
               beats_d        = beats_q + 1'b1;
               if (bus.req_last[owner_q] || (beats_q + 1'b1 == BEATS_W'(MAX_BURST))) begin
                  state_d    = IDLE;
                  last_ptr_d = owner_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign take_beat = bus.req_data[take_idx*DATA_W +: DATA_W];

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         last_ptr_q  <= PTR_W'(N_REQ - 1);
         owner_q     <= '0;
         beats_q     <= '0;
         fifo_wr_q   <= 1'b0;
         // NOTE: the data register is reset because its reset value is architecturally visible; wide data paths otherwise stay unreset.
         fifo_data_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
         state_q    <= state_d;
         last_ptr_q <= last_ptr_d;
         owner_q    <= owner_d;
         beats_q    <= beats_d;
         fifo_wr_q  <= take;
         if (take) fifo_data_q <= take_beat;
      end
   end

   assign bus.gnt       = rst ? gnt_c : '0;
   assign bus.fifo_wr   = fifo_wr_q;
   assign bus.fifo_data = fifo_data_q;
   assign bus.busy      = (state_q == BURST);

endmodule
